// File: rtl/poly_mod_diff.sv
// poly_mod_diff: pipelined modular difference o = (a - b) mod Q.
// The intermediate a - b + 2*Q is always non-negative and below 4*Q.
// Three conditional subtractions of Q therefore reduce it fully.
// Optional macro POLY_MOD_DIFF_PIPE_EN adds a register after the first
// reduction, which raises the latency from 1 to 2 clocks.
//
// Valid semantics: no ready/backpressure exists. A pair (a, b) is accepted
// on every rising edge where in_valid=1 and rst=0. out_valid=1 marks the
// cycle in which o carries that pair's result, in issue order, one per clock.
// While out_valid=0, o keeps its last value.
module poly_mod_diff #(
    parameter int WIDTH = 12,
    parameter int Q     = 3329
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH:0]   o
);

    // Three extra bits hold a + 2*Q without wrapping. The modular wrap of
    // the subtraction cancels because the final sum is non-negative.
    localparam int IW = WIDTH + 3;
    localparam logic [IW-1:0] QX  = IW'(Q);
    localparam logic [IW-1:0] QX2 = IW'(2 * Q);

    function automatic logic [IW-1:0] csub(input logic [IW-1:0] x);
        return (x >= QX) ? (x - QX) : x;
    endfunction

    logic [IW-1:0] diff;
    logic [IW-1:0] r1;
    logic [IW-1:0] s_r1;
    logic          s_val;
    logic [IW-1:0] r3;
    logic          unused_hi;

    // Subtraction with bias, then the first reduction step
    always_comb begin
        diff = {3'b000, a} - {3'b000, b} + QX2;
        r1   = csub(diff);
    end

`ifdef POLY_MOD_DIFF_PIPE_EN
    // Mid-pipeline register. Its valid bit is cleared on reset, so in-flight data is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_val <= 1'b0;
            s_r1  <= '0;
        end else begin
            s_val <= in_valid;
            if (in_valid) begin
                s_r1 <= r1;
            end
        end
    end
`else
    // Pass-through. The first reduction feeds the final reductions directly.
    always_comb begin
        s_val = in_valid;
        s_r1  = r1;
    end
`endif

    // Final two reduction steps. The result is below Q, so the upper bits are zero.
    always_comb begin
        r3        = csub(csub(s_r1));
        unused_hi = ^r3[IW-1:WIDTH+1];
    end

    // Output register. o only updates on valid results and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            o         <= '0;
        end else begin
            out_valid <= s_val;
            if (s_val) begin
                o <= r3[WIDTH:0];
            end
        end
    end

endmodule

// File: tb/tb_poly_mod_diff.sv
// Testbench for poly_mod_diff (WIDTH=12, Q=3329).
// The latency follows POLY_MOD_DIFF_PIPE_EN.
module tb_poly_mod_diff;

    localparam int WIDTH = 12;
    localparam int Q     = 3329;
`ifdef POLY_MOD_DIFF_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // clock / reset block
    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH:0]   o;

    always #5 clk = ~clk;

    poly_mod_diff #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .o        (o)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   exp;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    // scoreboard
    logic [WIDTH:0] exp_q[$];
    int             cyc_q[$];
    int             cyc     = 0;
    int             n_tests = 0;
    int             n_fail  = 0;
    logic [WIDTH:0] last_o  = '0;
    bit             mon_en  = 1'b0;

    function automatic logic [WIDTH:0] model(input int ia, input int ib);
        int d;
        d = (ia - ib) % Q;
        if (d < 0) d = d + Q;
        return (WIDTH+1)'(d);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_out();
        logic [WIDTH:0] e;
        int             c;
        if (!mon_en) return;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("result", int'(o), int'(e));
                check("latency", cyc - c, LAT);
            end
            last_o = o;
        end else begin
            check("hold", int'(o), int'(last_o));
            if (cyc_q.size() > 0 && cyc_q[0] + LAT <= cyc) begin
                check("missing_valid", 0, 1);
                void'(exp_q.pop_front());
                void'(cyc_q.pop_front());
            end
        end
    endtask

    // driver: one clock per call; check outputs first, then drive the next inputs
    task automatic tick(input logic r, input logic v, input logic [WIDTH-1:0] ia,
                        input logic [WIDTH-1:0] ib, input logic [WIDTH:0] e);
        @(negedge clk);
        check_out();
        rst      = r;
        in_valid = v;
        a        = ia;
        b        = ib;
        if (r) begin
            exp_q.delete();
            cyc_q.delete();
            last_o = '0;
        end else if (v) begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc);
        end
        cyc++;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        vecs[0]  = '{12'd0,    12'd4095, 13'd2563};
        vecs[1]  = '{12'd4095, 12'd0,    13'd766};
        vecs[2]  = '{12'd3329, 12'd0,    13'd0};
        vecs[3]  = '{12'd3328, 12'd0,    13'd3328};
        vecs[4]  = '{12'd0,    12'd1,    13'd3328};
        vecs[5]  = '{12'd1000, 12'd1000, 13'd0};
        vecs[6]  = '{12'd0,    12'd0,    13'd0};
        vecs[7]  = '{12'd4095, 12'd4095, 13'd0};
        vecs[8]  = '{12'd1,    12'd0,    13'd1};
        vecs[9]  = '{12'd3329, 12'd1,    13'd3328};
        vecs[10] = '{12'd100,  12'd3429, 13'd0};
        vecs[11] = '{12'd2000, 12'd500,  13'd1500};
        vecs[12] = '{12'd500,  12'd2000, 13'd1829};
        vecs[13] = '{12'd4095, 12'd1,    13'd765};
        vecs[14] = '{12'd1,    12'd4095, 13'd2564};
        vecs[15] = '{12'd3000, 12'd4000, 13'd2329};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        @(negedge clk);
        check("reset_o", int'(o), 0);
        check("reset_valid", int'(out_valid), 0);
        // in_valid during reset must be ignored
        tick(1'b1, 1'b1, 12'd5, 12'd3, 13'd2);
        mon_en = 1'b1;

        // table vectors, isolated by idle cycles
        for (int i = 0; i < NVEC; i++) begin
            tick(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
            tick(1'b0, 1'b0, 12'd0, 12'd0, 13'd0);
            tick(1'b0, 1'b0, 12'd0, 12'd0, 13'd0);
        end
        // table vectors back to back
        for (int i = 0; i < NVEC; i++)
            tick(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);

        // 1000 back-to-back random pairs
        for (int i = 0; i < 1000; i++) begin
            ra = 12'($urandom_range(0, 4095));
            rb = 12'($urandom_range(0, 4095));
            tick(1'b0, 1'b1, ra, rb, model(int'(ra), int'(rb)));
        end
        // random pairs with gaps; invalid cycles carry junk operands
        for (int i = 0; i < 100; i++) begin
            ra = 12'($urandom_range(0, 4095));
            rb = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) == 0)
                tick(1'b0, 1'b0, ra, rb, 13'd0);
            else
                tick(1'b0, 1'b1, ra, rb, model(int'(ra), int'(rb)));
        end

        // reset with two results in flight
        tick(1'b0, 1'b1, 12'd10, 12'd3,  13'd7);
        tick(1'b0, 1'b1, 12'd20, 12'd30, 13'd3319);
        tick(1'b1, 1'b0, 12'd0,  12'd0,  13'd0);
        @(negedge clk);
        check("rst_flight_o", int'(o), 0);
        check("rst_flight_valid", int'(out_valid), 0);
        rst = 1'b0;
        in_valid = 1'b0;
        cyc++;
        // no stale result may emerge after reset is released
        repeat (LAT + 3) tick(1'b0, 1'b0, 12'd0, 12'd0, 13'd0);
        tick(1'b0, 1'b1, 12'd7, 12'd9, 13'd3327);

        repeat (LAT + 2) tick(1'b0, 1'b0, 12'd0, 12'd0, 13'd0);
        if (exp_q.size() != 0) check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
